// File: rtl/adder_rv_fifo.sv
// Ready/valid adder: each accepted (a,b) pair produces {carry,sum}, which is queued in a DEPTH-entry FIFO and returned in order.
// Optional ADDER_RV_FIFO_STATS_EN adds counters for accepted transfers and input stall cycles.
module adder_rv_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_a,
  input  logic [W-1:0]               in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_sum,
  output logic                       out_carry,
`ifdef ADDER_RV_FIFO_STATS_EN
  output logic [31:0]                stat_accepted,
  output logic [31:0]                stat_stalls,
`endif
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned SW = W + 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [SW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_c;
  logic          pop_c;
  logic [LW-1:0] level_nxt_c;

  // Handshakes and next occupancy.
  always_comb begin
    push_c      = in_valid && in_ready;
    pop_c       = out_valid && out_ready;
    level_nxt_c = level;
    if (push_c && !pop_c) begin
      level_nxt_c = level + LW'(1);
    end else if (pop_c && !push_c) begin
      level_nxt_c = level - LW'(1);
    end
  end

  // Storage, pointers and flags. Flags are registered from the next occupancy,
  // so in_ready never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= SW'(in_a) + SW'(in_b);
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      level     <= level_nxt_c;
      in_ready  <= (level_nxt_c != LW'(DEPTH));
      out_valid <= (level_nxt_c != '0);
    end
  end

  assign out_sum   = mem[rd_ptr][W-1:0];
  assign out_carry = mem[rd_ptr][W];

`ifdef ADDER_RV_FIFO_STATS_EN
  // Wrapping event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_accepted <= '0;
      stat_stalls   <= '0;
    end else begin
      if (push_c) begin
        stat_accepted <= stat_accepted + 32'd1;
      end
      if (in_valid && !in_ready) begin
        stat_stalls <= stat_stalls + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // A stalled producer is expected to keep offering its pair.
  a_hold_valid: assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready) |=> in_valid)
    else $warning("in_valid dropped while stalled");
`endif

endmodule

// File: tb/tb_adder_rv_fifo.sv
// Self-checking bench for adder_rv_fifo: queue-based reference model checked every cycle, plus literal spot checks.
module tb_adder_rv_fifo;
  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_sum;
  logic          out_carry;
  logic [LW-1:0] level;
`ifdef ADDER_RV_FIFO_STATS_EN
  logic [31:0]   stat_accepted;
  logic [31:0]   stat_stalls;
`endif

  adder_rv_fifo #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
`ifdef ADDER_RV_FIFO_STATS_EN
    .stat_accepted(stat_accepted), .stat_stalls(stat_stalls),
`endif
    .level(level)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: a queue of pending {carry,sum} results.
  logic [W:0]  q[$];
  bit          m_rst = 1'b1;
  bit          chk_en = 1'b0;
  int unsigned m_acc = 0;
  int unsigned m_stall = 0;
  bit          m_ir;

  always @(posedge clk) begin
    m_ir = !m_rst && (q.size() != DEPTH);
    if (rst) begin
      q.delete();
      m_rst   = 1'b1;
      m_acc   = 0;
      m_stall = 0;
    end else begin
      if (in_valid && !m_ir) m_stall++;
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && m_ir) begin
        q.push_back({1'b0, in_a} + {1'b0, in_b});
        m_acc++;
      end
      m_rst = 1'b0;
    end
    chk_en = 1'b1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(!m_rst && (q.size() != DEPTH)));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("level", 64'(level), 64'(q.size()));
      if (q.size() != 0) begin
        chk("out_sum", 64'(out_sum), 64'(q[0][W-1:0]));
        chk("out_carry", 64'(out_carry), 64'(q[0][W]));
      end
`ifdef ADDER_RV_FIFO_STATS_EN
      chk("stat_accepted", 64'(stat_accepted), 64'(m_acc));
      chk("stat_stalls", 64'(stat_stalls), 64'(m_stall));
`endif
    end
  end

  // All drive tasks start and end at #1 after a posedge.
  task automatic wait_accept(input string name);
    bit acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_total++;
      $display("FAIL %s: handshake timeout, got no accept expected accept", name);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    wait_accept("send");
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // 1: reset held 4 cycles
    rst = 1'b1;
    cycles(4);
    @(negedge clk);
    chk("rst_in_ready_low", 64'(in_ready), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycles(1);
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_level", 64'(level), 64'd0);
    @(posedge clk);
    #1;

    // 2: eight back-to-back pairs with free-running consumer
    out_ready = 1'b1;
    send(32'd1, 32'd2);
    for (int k = 1; k < 8; k++) send(32'h10 * k, 32'h20 * k);
    drain();

    // 4: carry boundaries
    out_ready = 1'b0;
    send(32'hFFFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    chk("carry_wrap_sum", 64'(out_sum), 64'h0);
    chk("carry_wrap_c", 64'(out_carry), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    send(32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    chk("carry_mid_sum", 64'(out_sum), 64'h8000_0000);
    chk("carry_mid_c", 64'(out_carry), 64'd0);
    @(posedge clk);
    #1;
    drain();

    // 3: back-pressure with a fifth pair held off
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(32'd100 + k, 32'd7);
    in_a = 32'd555;
    in_b = 32'd444;
    in_valid = 1'b1;
    @(negedge clk);
    chk("full_level", 64'(level), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    in_a = 32'd600;           // data may change while stalled
    cycles(1);
    out_ready = 1'b1;
    cycles(1);
    @(negedge clk);
    chk("after_pop_level", 64'(level), 64'd3);
    chk("after_pop_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    wait_accept("fifth");
`ifdef ADDER_RV_FIFO_STATS_EN
    chk("stalls_seen", 64'(stat_stalls >= 32'd1), 64'd1);
`endif
    drain();

    // 5: random valid / ready traffic
    begin
      int sent = 0;
      bit acc;
      for (int c = 0; c < 5000 && (sent < 300 || in_valid); c++) begin
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) in_valid = 1'b0;
        if (!in_valid && sent < 300 && $urandom_range(0, 1) == 1) begin
          in_a = $urandom;
          in_b = (sent % 16 == 0) ? ~in_a : $urandom;
          in_valid = 1'b1;
          sent++;
        end
        out_ready = $urandom_range(0, 1) == 1;
      end
      in_valid = 1'b0;
      if (sent != 300) begin
        n_total++;
        $display("FAIL random_stream: sent %0d expected 300", sent);
      end
    end
    drain();

    // 6: reset with three results buffered
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(32'hA0 + k, 32'h1);
    @(negedge clk);
    chk("pre_rst_level", 64'(level), 64'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    cycles(1);
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycles(1);
    out_ready = 1'b0;
    send(32'd5, 32'd6);
    @(negedge clk);
    chk("fresh_sum", 64'(out_sum), 64'd11);
    @(posedge clk);
    #1;
    drain();
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
